// File: rtl/axi_lite_mmio_bridge_pkg.sv
// Shared constants and types for the AXI4-Lite to mmio_if bridge and other mmio hosts.
package axi_lite_mmio_bridge_pkg;

  localparam int TIA_MMIO_INDEX_WIDTH = 8;
  localparam int TIA_MMIO_DATA_WIDTH  = 32;

  localparam logic [1:0] TIA_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] TIA_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] TIA_AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE_REQ,
    ST_WRITE_RESP,
    ST_READ_REQ,
    ST_READ_RESP
  } bridge_state_e;

  // Response a write earns before reaching the mapper; OKAY means it may be issued.
  function automatic logic [1:0] write_precheck(input logic addr_hi, input logic [3:0] strb);
    if (addr_hi)          return TIA_AXI_RESP_DECERR;
    else if (strb != 4'hF) return TIA_AXI_RESP_SLVERR;
    else                  return TIA_AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/mmio_if.sv
// Word-indexed request/ack port between an mmio host and the core memory mapper.
interface mmio_if;
  import axi_lite_mmio_bridge_pkg::*;

  logic                            read_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
  logic                            read_ack;
  logic                            write_req;
  logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
  logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
  logic                            write_ack;

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_data, read_ack, write_ack
  );

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_data, read_ack, write_ack
  );
endinterface

// File: rtl/mmio_timeout_counter.sv
// Request watchdog: counts cycles while enabled and flags the last allowed cycle.
module mmio_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/axi_lite_mmio_bridge.sv
// AXI4-Lite slave serialising host reads/writes onto a single-outstanding mmio_if port,
// with a per-request timeout so unmapped indices cannot stall the host bus.
module axi_lite_mmio_bridge
  import axi_lite_mmio_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  mmio_if.host                  mmio_interface
);

  localparam int IW = TIA_MMIO_INDEX_WIDTH;

  bridge_state_e r_state;
  logic          r_last_rd;
  logic          r_awready, r_wready, r_arready;
  logic          r_bvalid, r_rvalid;
  logic [1:0]    r_bresp, r_rresp;
  logic [31:0]   r_rdata;
  logic          r_wreq, r_rreq;
  logic [IW-1:0] r_widx, r_ridx;
  logic [31:0]   r_wdata;

  logic       w_wr_pend, w_rd_pend, w_pick_wr, w_pick_rd;
  logic       w_aw_hi, w_ar_hi, w_in_req, w_expired;
  logic [1:0] w_wr_pre;

  assign w_wr_pend = awvalid && wvalid;
  assign w_rd_pend = arvalid;
  // On contention the kind not served last wins.
  assign w_pick_wr = w_wr_pend && (!w_rd_pend || r_last_rd);
  assign w_pick_rd = w_rd_pend && !w_pick_wr;

  assign w_aw_hi  = |(awaddr >> (IW + 2));
  assign w_ar_hi  = |(araddr >> (IW + 2));
  assign w_wr_pre = write_precheck(w_aw_hi, wstrb);
  assign w_in_req = (r_state == ST_WRITE_REQ) || (r_state == ST_READ_REQ);

  mmio_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .i_clk     (clk),
    .i_rst_n   (n_reset),
    .i_clear   (!w_in_req),
    .i_enable  (w_in_req),
    .o_expired (w_expired)
  );

  // Readies are registered: they are armed from valids seen one cycle earlier (in IDLE,
  // or during the closing response cycle so back-to-back traffic loses no cycle).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_last_rd <= 1'b1;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= TIA_AXI_RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= TIA_AXI_RESP_OKAY;
      r_rdata   <= '0;
      r_wreq    <= 1'b0;
      r_widx    <= '0;
      r_wdata   <= '0;
      r_rreq    <= 1'b0;
      r_ridx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_awready) begin
            if (w_wr_pend) begin
              r_awready <= 1'b0;
              r_wready  <= 1'b0;
              r_last_rd <= 1'b0;
              r_widx    <= awaddr[IW+1:2];
              r_wdata   <= wdata;
              if (w_wr_pre != TIA_AXI_RESP_OKAY) begin
                r_bresp  <= w_wr_pre;
                r_bvalid <= 1'b1;
                r_state  <= ST_WRITE_RESP;
              end else begin
                r_wreq  <= 1'b1;
                r_state <= ST_WRITE_REQ;
              end
            end
          end else if (r_arready) begin
            if (arvalid) begin
              r_arready <= 1'b0;
              r_last_rd <= 1'b1;
              r_ridx    <= araddr[IW+1:2];
              if (w_ar_hi) begin
                r_rresp  <= TIA_AXI_RESP_DECERR;
                r_rdata  <= '0;
                r_rvalid <= 1'b1;
                r_state  <= ST_READ_RESP;
              end else begin
                r_rreq  <= 1'b1;
                r_state <= ST_READ_REQ;
              end
            end
          end else begin
            r_awready <= w_pick_wr;
            r_wready  <= w_pick_wr;
            r_arready <= w_pick_rd;
          end
        end
        // Ack is tested before expiry so an ack on the final cycle still succeeds.
        ST_WRITE_REQ: begin
          if (mmio_interface.write_ack) begin
            r_wreq   <= 1'b0;
            r_bresp  <= TIA_AXI_RESP_OKAY;
            r_bvalid <= 1'b1;
            r_state  <= ST_WRITE_RESP;
          end else if (w_expired) begin
            r_wreq   <= 1'b0;
            r_bresp  <= TIA_AXI_RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_state  <= ST_WRITE_RESP;
          end
        end
        ST_WRITE_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_state   <= ST_IDLE;
            r_awready <= w_pick_wr;
            r_wready  <= w_pick_wr;
            r_arready <= w_pick_rd;
          end
        end
        ST_READ_REQ: begin
          if (mmio_interface.read_ack) begin
            r_rreq   <= 1'b0;
            r_rdata  <= mmio_interface.read_data;
            r_rresp  <= TIA_AXI_RESP_OKAY;
            r_rvalid <= 1'b1;
            r_state  <= ST_READ_RESP;
          end else if (w_expired) begin
            r_rreq   <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= TIA_AXI_RESP_SLVERR;
            r_rvalid <= 1'b1;
            r_state  <= ST_READ_RESP;
          end
        end
        ST_READ_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_state   <= ST_IDLE;
            r_awready <= w_pick_wr;
            r_wready  <= w_pick_wr;
            r_arready <= w_pick_rd;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign arready = r_arready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

  assign mmio_interface.write_req   = r_wreq;
  assign mmio_interface.write_index = r_widx;
  assign mmio_interface.write_data  = r_wdata;
  assign mmio_interface.read_req    = r_rreq;
  assign mmio_interface.read_index  = r_ridx;

endmodule

// File: tb/tb_axi_lite_mmio_bridge.sv
// Directed and randomized bench for axi_lite_mmio_bridge against a transaction-level model.
module tb_axi_lite_mmio_bridge;
  import axi_lite_mmio_bridge_pkg::*;

  localparam int AW   = 32;
  localparam int T    = 8;
  localparam int IW   = TIA_MMIO_INDEX_WIDTH;
  localparam int NMAP = 192;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = 4'hF;
  logic          bready = 1'b1, rready = 1'b1;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  mmio_if mi();

  axi_lite_mmio_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_reset(n_reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .mmio_interface(mi)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int ack_lat = 1;
  int whi = 0, rhi = 0, both = 0;
  int wcnt = 0, rcnt = 0;
  bit dev_init = 1'b0;
  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_widx = '0, last_wdata = '0;

  function automatic logic [31:0] seed(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Mapper model: acks mapped indices in the ack_lat-th req cycle, never acks unmapped ones.
  always @(negedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] = seed(i);
      dev_init = 1'b1;
    end
    if (mi.write_req) begin
      wcnt++;
      if (wcnt == ack_lat && int'(mi.write_index) < NMAP) begin
        mi.write_ack = 1'b1;
        dev_mem[mi.write_index] = mi.write_data;
        last_widx  = 32'(mi.write_index);
        last_wdata = mi.write_data;
      end else mi.write_ack = 1'b0;
    end else begin
      wcnt = 0;
      mi.write_ack = 1'b0;
    end
    if (mi.read_req) begin
      rcnt++;
      if (rcnt == ack_lat && int'(mi.read_index) < NMAP) begin
        mi.read_ack  = 1'b1;
        mi.read_data = dev_mem[mi.read_index];
      end else begin
        mi.read_ack  = 1'b0;
        mi.read_data = 32'hBAD0_BAD0;
      end
    end else begin
      rcnt = 0;
      mi.read_ack  = 1'b0;
      mi.read_data = 32'hBAD0_BAD0;
    end
    if (mi.write_req) whi++;
    if (mi.read_req) rhi++;
    if (mi.write_req && mi.read_req) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; expectations come from address/strobe/latency rules only.
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lat);
    int idx, rq, ec, c, h0;
    logic [1:0] er;
    logic [31:0] erd;
    bit ok, hi;
    idx = int'(addr[IW+1:2]);
    hi  = (addr >> (IW + 2)) != 0;
    if (hi)                    begin er = TIA_AXI_RESP_DECERR; rq = 0;   end
    else if (wr && strb != 4'hF) begin er = TIA_AXI_RESP_SLVERR; rq = 0; end
    else if (idx >= NMAP)      begin er = TIA_AXI_RESP_SLVERR; rq = T;   end
    else if (lat > T)          begin er = TIA_AXI_RESP_SLVERR; rq = T;   end
    else                       begin er = TIA_AXI_RESP_OKAY;   rq = lat; end
    ec  = (rq == 0) ? 1 : rq + 1;
    erd = (!wr && er == TIA_AXI_RESP_OKAY) ? ref_mem[idx] : 32'h0;
    if (wr && er == TIA_AXI_RESP_OKAY) ref_mem[idx] = data;

    ack_lat = lat;
    @(negedge clk);
    h0 = wr ? whi : rhi;
    if (wr) begin awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; end
    else    begin araddr = addr; arvalid = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr ? awready : arready) begin ok = 1'b1; break; end
    end
    chk(wr ? "aw_handshake" : "ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    ok = 1'b0; c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); c++;
      if (wr ? bvalid : rvalid) begin ok = 1'b1; break; end
    end
    chk(wr ? "bvalid_seen" : "rvalid_seen", 32'(ok), 32'd1);
    chk(wr ? "bresp" : "rresp", 32'(wr ? bresp : rresp), 32'(er));
    chk(wr ? "wr_resp_latency" : "rd_resp_latency", 32'(c), 32'(ec));
    chk(wr ? "write_req_cycles" : "read_req_cycles", 32'((wr ? whi : rhi) - h0), 32'(rq));
    if (!wr) chk("rdata", rdata, erd);
    if (wr && er == TIA_AXI_RESP_OKAY) begin
      chk("write_index", last_widx, 32'(idx));
      chk("write_data", last_wdata, data);
    end
    @(posedge clk); #1;
  endtask

  // Both kinds pending at once; reports which handshake came first.
  task automatic contend(input logic [31:0] wa, input logic [31:0] ra, output int first_wr);
    int nb, nr;
    bit whs, rhs;
    first_wr = -1; nb = 0; nr = 0;
    ack_lat = 1;
    @(negedge clk);
    awaddr = wa; wdata = 32'hC0DE_0000 ^ wa; wstrb = 4'hF; araddr = ra;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 60 && (nb == 0 || nr == 0); i++) begin
      @(negedge clk);
      whs = awready && awvalid;
      rhs = arready && arvalid;
      if (whs && first_wr < 0) first_wr = 1;
      if (rhs && first_wr < 0) first_wr = 0;
      if (bvalid) begin nb++; chk("contend_bresp", 32'(bresp), 32'(TIA_AXI_RESP_OKAY)); end
      if (rvalid) begin nr++; chk("contend_rresp", 32'(rresp), 32'(TIA_AXI_RESP_OKAY)); end
      @(posedge clk); #1;
      if (whs) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (rhs) arvalid = 1'b0;
    end
    chk("contend_both_done", 32'(nb == 1 && nr == 1), 32'd1);
    ref_mem[wa[IW+1:2]] = 32'hC0DE_0000 ^ wa;
  endtask

  initial begin
    int fw;
    bit ok;
    bit wr;
    logic [31:0] a;
    logic [3:0] s;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);

    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready",  32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid",  32'(bvalid), 0);
    chk("rst_rvalid",  32'(rvalid), 0);
    chk("rst_bresp",   32'(bresp), 0);
    chk("rst_rresp",   32'(rresp), 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_wreq",    32'(mi.write_req), 0);
    chk("rst_rreq",    32'(mi.read_req), 0);
    chk("rst_widx",    32'(mi.write_index), 0);
    chk("rst_ridx",    32'(mi.read_index), 0);
    chk("rst_wdata",   mi.write_data, 0);
    n_reset = 1'b1;

    // Contended from reset: write first, then read, twice over.
    contend(32'h0000_0100, 32'h0000_0104, fw);
    chk("contend1_write_first", 32'(fw), 1);
    contend(32'h0000_0108, 32'h0000_0100, fw);
    chk("contend2_write_first", 32'(fw), 1);

    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2);
    xact(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1);
    xact(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1);
    xact(1'b0, 32'(200 << 2), 32'h0, 4'hF, 1);
    xact(1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'h3, 1);
    xact(1'b1, 32'h0001_0040, 32'h5555_AAAA, 4'hF, 1);
    xact(1'b0, 32'h8000_0004, 32'h0, 4'hF, 1);
    xact(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, T);
    xact(1'b1, 32'h0000_0034, 32'h0BAD_F00D, 4'hF, T + 1);

    // Reset while the read is still waiting on the mapper.
    ack_lat = 100; rready = 1'b0;
    @(negedge clk);
    araddr = 32'h0000_000C; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    chk("rst_test_handshake", 32'(ok), 1);
    @(posedge clk); #1; arvalid = 1'b0;
    @(negedge clk);
    chk("rst_test_req_high", 32'(mi.read_req), 1);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("midrst_rreq",    32'(mi.read_req), 0);
    chk("midrst_ridx",    32'(mi.read_index), 0);
    chk("midrst_rvalid",  32'(rvalid), 0);
    chk("midrst_arready", 32'(arready), 0);
    chk("midrst_rdata",   rdata, 0);
    chk("midrst_rresp",   32'(rresp), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1; rready = 1'b1;
    xact(1'b0, 32'h0000_000C, 32'h0, 4'hF, 1);

    for (int n = 0; n < 24; n++) begin
      int r;
      r  = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      if (r == 0)      a = ($urandom_range(1, 255) << (IW + 2)) | ($urandom_range(0, 255) << 2);
      else if (r == 1) a = 32'($urandom_range(NMAP, 255)) << 2;
      else             a = 32'($urandom_range(0, NMAP - 1)) << 2;
      a = a | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      xact(wr, a, $urandom, s, int'($urandom_range(1, 10)));
    end

    chk("req_never_both", 32'(both), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
